conv_enc_frame_ctrl: RTL and testbench

Frame sequencer for the rate-1/2 convolutional encoder (conv_encoder_1_2). On start it loads the encoder seed, streams a programmed number of payload bits into the encoder, then optionally appends M zero tail bits to flush the encoder to state 0. Encoder symbols are buffered in a 2-entry output FIFO with valid/ready backpressure and a last-symbol marker. It sits between the payload source and the channel/decoder path.

---
 rtl/conv_enc_frame_ctrl.sv | 129 ++++++++++++
 tb/tb_conv_enc_frame_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/conv_enc_frame_ctrl.sv
// conv_enc_frame_ctrl: frame sequencer for conv_encoder_1_2 (seed, payload, zero tail, 2-entry symbol FIFO); CONV_FRAME_STATS_EN adds stat_frames/stat_syms
module conv_enc_frame_ctrl #(
  parameter int K = 5,
  parameter int LEN_W = 16,
  localparam int M = K - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [M-1:0]     cfg_seed,
  input  logic             cfg_tail,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             enc_seed_load,
  output logic [M-1:0]     enc_seed_value,
  output logic             enc_in_valid,
  output logic             enc_in_bit,
  input  logic             enc_out_valid,
  input  logic [1:0]       enc_out_sym,
  output logic             sym_valid,
  output logic [1:0]       sym_data,
  output logic             sym_last,
  input  logic             sym_ready,
  output logic             busy,
  output logic             done,
  output logic             err_unexp
`ifdef CONV_FRAME_STATS_EN
  ,
  output logic [15:0]      stat_frames,
  output logic [31:0]      stat_syms
`endif
);
  typedef enum logic [2:0] {IDLE, SEED, DATA, TAIL, DRAIN} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [M-1:0] seed_q, seed_d;
  logic tail_q, tail_d;
  logic infl_q, infl_last_q, err_q;
  logic [1:0] cnt_q, res;
  logic [2:0] s0_q, s1_q;
  logic credit, pop, push, issue, is_last;
  // reserved = FIFO occupancy plus the symbol the encoder is producing this cycle
  assign res = cnt_q + {1'b0, infl_q};
  assign credit = !res[1];
  assign sym_valid = cnt_q != 2'd0;
  assign sym_data = s0_q[1:0];
  assign sym_last = s0_q[2];
  assign pop = sym_valid && sym_ready;
  assign push = enc_out_valid && infl_q;
  assign enc_seed_load = state_q == SEED;
  assign enc_seed_value = seed_q;
  assign enc_in_valid = issue;
  assign enc_in_bit = in_ready && in_valid && in_bit;
  assign err_unexp = err_q;
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    tail_d = tail_q;
    seed_d = seed_q;
    in_ready = state_q == DATA && credit;
    issue = (in_ready && in_valid) || (state_q == TAIL && credit);
    is_last = issue && rem_q == LEN_W'(1) && (state_q == TAIL || !tail_q);
    done = state_q == DRAIN && (res == 2'd0 || (pop && sym_last));
    busy = state_q != IDLE && !done;
    if (issue) rem_d = rem_q - LEN_W'(1);
    case (state_q)
      SEED: begin
        state_d = rem_q != '0 ? DATA : tail_q ? TAIL : DRAIN;
        if (rem_q == '0) rem_d = LEN_W'(M);
      end
      DATA: if (issue && rem_q == LEN_W'(1)) begin
        state_d = tail_q ? TAIL : DRAIN;
        rem_d = LEN_W'(M);
      end
      TAIL: if (issue && rem_q == LEN_W'(1)) state_d = DRAIN;
      DRAIN: if (done) state_d = IDLE;
      default: ;
    endcase
    if (start && !busy) begin
      state_d = SEED;
      rem_d = cfg_len;
      tail_d = cfg_tail;
      seed_d = cfg_seed;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q <= '0;
      tail_q <= 1'b0;
      seed_q <= '0;
      infl_q <= 1'b0;
      infl_last_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= 2'd0;
      s0_q <= 3'd0;
      s1_q <= 3'd0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      tail_q <= tail_d;
      seed_q <= seed_d;
      infl_q <= issue;
      infl_last_q <= is_last;
      err_q <= err_q || (enc_out_valid && !infl_q);
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
      if (pop) s0_q <= cnt_q == 2'd2 ? s1_q : {infl_last_q, enc_out_sym};
      else if (push && cnt_q == 2'd0) s0_q <= {infl_last_q, enc_out_sym};
      if (push && (cnt_q == 2'd2 || (cnt_q == 2'd1 && !pop))) s1_q <= {infl_last_q, enc_out_sym};
    end
  end
`ifdef CONV_FRAME_STATS_EN
  logic [15:0] frames_q;
  logic [31:0] syms_q;
  assign stat_frames = frames_q;
  assign stat_syms = syms_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      frames_q <= 16'd0;
      syms_q <= 32'd0;
    end else begin
      frames_q <= frames_q + {15'd0, done};
      syms_q <= syms_q + {31'd0, pop};
    end
  end
`endif
endmodule

// File: tb/tb_conv_enc_frame_ctrl.sv
// tb_conv_enc_frame_ctrl: directed bench with a behavioural (35,23)_8 K=5 encoder behind the sequencer
module tb_conv_enc_frame_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cfg_tail = 1'b0, in_valid = 1'b0;
  logic [15:0] cfg_len = 16'd0, pbits = 16'd0;
  logic [3:0] cfg_seed = 4'd0, bit_idx = 4'd0;
  logic in_bit, in_ready, enc_seed_load, enc_in_valid, enc_in_bit, enc_out_valid;
  logic [3:0] enc_seed_value, es_s = 4'd0;
  logic [1:0] enc_out_sym, es_sym = 2'd0, sym_data;
  logic es_v = 1'b0, spur = 1'b0, bp_en = 1'b0;
  logic sym_valid, sym_last, sym_ready, busy, done, err_unexp;
`ifdef CONV_FRAME_STATS_EN
  logic [15:0] stat_frames;
  logic [31:0] stat_syms;
`endif
  int total = 0, passed = 0, cyc = 0, done_cnt = 0, done_cyc = 0, seed_cyc = 0, res_m = 0;
  logic stall_v = 1'b0;
  logic [2:0] held = 3'd0;
  logic [2:0] symq[$];

  always #5 clk = ~clk;
  assign in_bit = pbits[bit_idx];
  assign sym_ready = !bp_en || (cyc % 3 == 0);
  assign enc_out_valid = es_v || spur;
  assign enc_out_sym = spur ? 2'b11 : es_sym;

  conv_enc_frame_ctrl #(.K(5), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_seed(cfg_seed),
    .cfg_tail(cfg_tail), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .enc_seed_load(enc_seed_load), .enc_seed_value(enc_seed_value),
    .enc_in_valid(enc_in_valid), .enc_in_bit(enc_in_bit),
    .enc_out_valid(enc_out_valid), .enc_out_sym(enc_out_sym),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_last(sym_last), .sym_ready(sym_ready),
    .busy(busy), .done(done), .err_unexp(err_unexp)
`ifdef CONV_FRAME_STATS_EN
    , .stat_frames(stat_frames), .stat_syms(stat_syms)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // encoder model: es_s[3] is the most recent past bit, es_s[0] the oldest
  always @(posedge clk) begin
    if (rst) begin
      es_v <= 1'b0;
      es_s <= 4'd0;
    end else begin
      es_v <= enc_in_valid;
      if (enc_seed_load) es_s <= enc_seed_value;
      else if (enc_in_valid) begin
        es_sym <= {enc_in_bit ^ es_s[3] ^ es_s[2] ^ es_s[0], enc_in_bit ^ es_s[1] ^ es_s[0]};
        es_s <= {enc_in_bit, es_s[3:1]};
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    bit_idx <= (rst || enc_seed_load) ? 4'd0 : bit_idx + 4'(in_valid && in_ready);
    if (stall_v) chk("stall_hold", {29'd0, sym_valid, sym_last, sym_data}, {29'd0, 1'b1, held});
    if (res_m >= 2) chk("credit_block", {31'd0, in_ready}, 32'd0);
    if (rst) begin
      res_m = 0;
      stall_v = 1'b0;
    end else begin
      res_m = res_m + (enc_in_valid ? 1 : 0) - ((sym_valid && sym_ready) ? 1 : 0);
      if (sym_valid && sym_ready) symq.push_back({sym_last, sym_data});
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (enc_seed_load) seed_cyc = cyc;
      stall_v = sym_valid && !sym_ready;
      held = {sym_last, sym_data};
    end
  end

  task automatic run_frame(input logic [15:0] len, input logic [3:0] seed, input logic tl,
                           input logic [15:0] bits, input int nsym, input logic [15:0] exp,
                           input logic bp, input logic poke, input string tag);
    int qb, db;
    qb = symq.size();
    db = done_cnt;
    pbits = bits;
    bp_en = bp;
    @(negedge clk);
    cfg_len = len; cfg_seed = seed; cfg_tail = tl; start = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0; cfg_len = 16'd0; cfg_seed = 4'd0; cfg_tail = 1'b0;
    for (int i = 0; i < 300 && done_cnt == db; i++) begin
      @(negedge clk);
      start = poke && i == 2;
      cfg_len = poke && i == 2 ? 16'd1 : 16'd0;
    end
    start = 1'b0; in_valid = 1'b0; cfg_len = 16'd0;
    chk({tag, "_done"}, done_cnt - db, 1);
    repeat (3) @(negedge clk);
    chk({tag, "_once"}, done_cnt - db, 1);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_count"}, symq.size() - qb, nsym);
    for (int i = 0; i < nsym; i++)
      chk($sformatf("%s_sym%0d", tag, i),
          (qb + i < symq.size()) ? {29'd0, symq[qb + i]} : 32'h8,
          {29'd0, i == nsym - 1, exp[2*i +: 2]});
    bp_en = 1'b0;
  endtask

  initial begin
    int qb;
    repeat (3) @(negedge clk);
    chk("reset_outs", {23'd0, sym_valid, sym_last, sym_data, busy, done, in_ready, enc_seed_load, enc_in_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", {25'd0, sym_valid, busy, done, in_ready, enc_seed_load, enc_in_valid, err_unexp}, 32'd0);
    run_frame(16'd4, 4'd0, 1'b1, 16'h000D, 8, 16'hEF1B, 1'b0, 1'b0, "basic");
    run_frame(16'd4, 4'd0, 1'b1, 16'h000D, 8, 16'hEF1B, 1'b1, 1'b0, "bp");
    run_frame(16'd3, 4'd0, 1'b0, 16'h0007, 3, 16'h0037, 1'b0, 1'b1, "notail");
    run_frame(16'd0, 4'd0, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 1'b0, "degen");
    chk("degen_latency", done_cyc - seed_cyc, 1);
    run_frame(16'd1, 4'hF, 1'b1, 16'h0000, 5, 16'h00E2, 1'b0, 1'b0, "seeded");
    qb = symq.size();
    pbits = 16'h000D;
    bp_en = 1'b1;
    @(negedge clk);
    cfg_len = 16'd4; cfg_tail = 1'b1; start = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && symq.size() - qb < 2; i++) @(negedge clk);
    chk("midrst_reach", {31'd0, symq.size() - qb >= 2}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outs", {23'd0, sym_valid, sym_last, sym_data, busy, done, in_ready, enc_in_valid, err_unexp}, 32'd0);
    rst = 1'b0; in_valid = 1'b0; bp_en = 1'b0; cfg_len = 16'd0; cfg_tail = 1'b0;
    run_frame(16'd4, 4'd0, 1'b1, 16'h000D, 8, 16'hEF1B, 1'b0, 1'b0, "clean");
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    chk("err_set", {30'd0, err_unexp, sym_valid}, 32'd2);
    repeat (5) @(negedge clk);
    chk("err_sticky", {31'd0, err_unexp}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("err_clear", {31'd0, err_unexp}, 32'd0);
`ifdef CONV_FRAME_STATS_EN
    chk("stats_reset", {stat_frames, stat_syms[15:0]}, 32'd0);
    for (int f = 0; f < 3; f++) run_frame(16'd4, 4'd0, 1'b1, 16'h000D, 8, 16'hEF1B, 1'b0, 1'b0, "stat");
    chk("stat_frames", {16'd0, stat_frames}, 32'd3);
    chk("stat_syms", stat_syms, 32'd24);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
